// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// Build option: PISO_PARITY_EN adds a trailing even-parity beat to every word.
package piso_pkg;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_e;
`else
    typedef enum logic {IDLE, SHIFT} piso_state_e;
`endif

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register for the PISO serializer: queues the next word while
// the current one shifts out.
module piso_hold_buf #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             full_next
);

    // Exposed so the parent can register in_ready without a combinational path.
    assign full_next = load | (full & ~take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            full <= full_next;
            if (load) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, MSB first, with a one-word holding register.
// Build option: PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             in_ready_q;
    logic             hold_load, hold_take, hold_full, hold_full_next;
    logic [WIDTH-1:0] hold_data;
    logic             accept, consume, last_beat, load_en;
    logic [WIDTH-1:0] load_word;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign accept  = in_valid & in_ready_q;
    assign consume = ser_valid & ser_ready;

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .take     (hold_take),
        .load_data(in_data),
        .data     (hold_data),
        .full     (hold_full),
        .full_next(hold_full_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            in_ready_q <= ~hold_full_next;
`ifdef PISO_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        hold_load = 1'b0;
        hold_take = 1'b0;
        last_beat = 1'b0;
        load_en   = 1'b0;
        load_word = in_data;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                load_en = accept;
            end
            SHIFT: begin
                if (consume) begin
                    if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        last_beat = 1'b1;
`endif
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - CntW'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                last_beat = consume;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Chain the next word into the shifter on the final beat so words run gap-free.
        if (last_beat) begin
            if (hold_full) begin
                load_en   = 1'b1;
                load_word = hold_data;
                hold_take = 1'b1;
            end else if (accept) begin
                load_en = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (accept && (state_q != IDLE)) begin
            hold_load = 1'b1;
        end

        if (load_en) begin
            state_d  = SHIFT;
            shift_d  = load_word;
            cnt_d    = CntW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            parity_d = ^load_word;
`endif
        end
    end

    always_comb begin
        ser_valid = (state_q != IDLE);
        busy      = (state_q != IDLE) | hold_full;
        in_ready  = in_ready_q;
`ifdef PISO_PARITY_EN
        ser_out   = (state_q == PARITY) ? parity_q : shift_q[WIDTH-1];
        ser_last  = (state_q == PARITY);
`else
        ser_out   = shift_q[WIDTH-1];
        ser_last  = (state_q == SHIFT) && (cnt_q == '0);
`endif
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a scoreboard queue of expected serial
// beats is filled on accept and drained by a monitor on every consumed bit.
module tb_piso_serializer;

    localparam int unsigned WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int unsigned NB = WIDTH + 1;
`else
    localparam int unsigned NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready = 1'b0;
    logic             ser_last;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] sb[$];  // {bit, last}
    logic [1:0] mon_exp;

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .ser_ready(ser_ready),
        .ser_last (ser_last),
        .busy     (busy)
    );

    // Consumed beats are checked against the scoreboard in order.
    always @(negedge clk) begin
        if (rst_n && ser_valid && ser_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bit: got out=%b last=%b, required no bit", ser_out,
                         ser_last);
            end else begin
                mon_exp = sb.pop_front();
                if ({ser_out, ser_last} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL serial_bit: got out=%b last=%b, required out=%b last=%b",
                             ser_out, ser_last, mon_exp[1], mon_exp[0]);
                end
            end
        end
    end

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
            sb.push_back({w[i], 1'b0});
`else
            sb.push_back({w[i], i == 0});
`endif
        end
`ifdef PISO_PARITY_EN
        sb.push_back({^w, 1'b1});
`endif
    endtask

    task automatic offer(input logic [WIDTH-1:0] w, input string name);
        bit got = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                push_word(w);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_accept: got no accept, required accept within 20 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got busy=%b pending=%0d, required busy=0 pending=0", name,
                     busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, ser_out, ser_valid, ser_last, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 00000",
                     {in_ready, ser_out, ser_valid, ser_last, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, ser_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL ready_after_edge: got ready/valid/busy=%b, required 100",
                     {in_ready, ser_valid, busy});
        end
    endtask

    task automatic test_single();
        ser_ready = 1'b1;
        offer(4'b1010, "single");
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            n_tests++;
            if ({ser_valid, busy} !== 2'b11) begin
                n_fail++;
                $display("FAIL single_valid: beat %0d got valid/busy=%b, required 11", k,
                         {ser_valid, busy});
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_tests++;
        if ({ser_valid, busy, sb.size() == 0} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_end: got valid=%b busy=%b pending=%0d, required 0 0 0",
                     ser_valid, busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        ser_ready = 1'b1;
        offer(4'b1010, "b2b_first");
        in_data  = 4'b1100;
        in_valid = 1'b1;
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            n_tests++;
            if (ser_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid: beat %0d got %b, required 1", i, ser_valid);
            end
            if (i == 0) begin
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: got %b, required 1", in_ready);
                end else begin
                    push_word(4'b1100);
                end
            end
            @(posedge clk);
            #1;
            if (i == 0) in_valid = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if ({ser_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got valid/busy=%b, required 00", {ser_valid, busy});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        ser_ready = 1'b1;
        offer(4'b0111, "stall");
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if ({ser_out, ser_valid, ser_last} !== 3'b110) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d got out/valid/last=%b, required 110", k,
                         {ser_out, ser_valid, ser_last});
            end
            @(posedge clk);
            #1;
        end
        ser_ready = 1'b1;
        wait_drain("stall");
    endtask

    task automatic test_hold_full();
        ser_ready = 1'b1;
        in_data   = 4'b1010;
        in_valid  = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_first_ready: got %b, required 1", in_ready);
        end
        push_word(4'b1010);
        @(posedge clk);
        #1;
        in_data = 4'b0011;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_second_ready: got %b, required 1", in_ready);
        end
        push_word(4'b0011);
        @(posedge clk);
        #1;
        in_data = 4'b1111;
        for (int k = 0; k < NB - 1; k++) begin
            @(negedge clk);
            n_tests++;
            if ({in_ready, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL hold_blocked: cycle %0d got ready/busy=%b, required 01", k,
                         {in_ready, busy});
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reopen: got %b, required 1", in_ready);
        end else begin
            push_word(4'b1111);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain("hold");
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        ser_ready = 1'b1;
        offer(4'b0111, "parity_odd");
        wait_drain("parity_odd");
        offer(4'b1010, "parity_even");
        wait_drain("parity_even");
    endtask
`endif

    task automatic test_reset_mid();
        ser_ready = 1'b1;
        in_data   = 4'b1010;
        in_valid  = 1'b1;
        @(negedge clk);
        push_word(4'b1010);
        @(posedge clk);
        #1;
        in_data = 4'b0011;
        @(negedge clk);
        push_word(4'b0011);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_held: got ready/busy=%b, required 01", {in_ready, busy});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, ser_out, ser_valid, ser_last, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got %b, required 00000",
                     {in_ready, ser_out, ser_valid, ser_last, busy});
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_ready_before_edge: got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_ready_after_edge: got ready/busy=%b, required 10",
                     {in_ready, busy});
        end
        offer(4'b0110, "rmid_next");
        wait_drain("rmid_next");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish before 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_hold_full();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
